reg_wb_ctrl: RTL and testbench

- Write-back controller: the initiator side of the register bank's write port.
- Accepts 32-bit results from the execute/load stages over a valid/ready handshake and buffers them in a small in-order queue.
- Drains one entry per cycle onto the bank's rd_addr/rd_data/rd_we lines.
- Provides two forwarding lookups so operand fetch sees values that are queued or in flight but not yet written.

---
 rtl/reg_wb_ctrl.sv | 138 +++++++++++++
 tb/tb_reg_wb_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_ctrl.sv
// Write-back controller: queues results in order and drains one per cycle into the register bank.
// Optional build macro WB_BYPASS_EN lets a result go straight to the output register when the queue is empty.
module reg_wb_ctrl #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          res_valid,
  output logic          res_ready,
  input  logic [AW-1:0] res_addr,
  input  logic [DW-1:0] res_data,
  output logic          rd_we,
  output logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data,
  input  logic [AW-1:0] q1_addr,
  output logic          q1_hit,
  output logic [DW-1:0] q1_data,
  input  logic [AW-1:0] q2_addr,
  output logic          q2_hit,
  output logic [DW-1:0] q2_data,
  output logic          busy
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          rd_we_q, rd_we_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic [DW-1:0] rd_data_q, rd_data_d;

  logic accept;
  logic push;
  logic pop;
  logic bypass;

  assign res_ready = !rst && (count_q < CW'(DEPTH));
  assign accept    = res_valid && res_ready;
  assign pop       = (count_q != '0);

`ifdef WB_BYPASS_EN
  assign bypass = accept && (res_addr != '0) && !pop;
`else
  assign bypass = 1'b0;
`endif

  assign push = accept && (res_addr != '0) && !bypass;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    rd_we_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    rd_data_d = rd_data_q;
    if (pop) begin
      rd_ptr_d  = rd_ptr_q + 1'b1;
      rd_we_d   = 1'b1;
      rd_addr_d = addr_q[rd_ptr_q];
      rd_data_d = data_q[rd_ptr_q];
    end else if (bypass) begin
      rd_we_d   = 1'b1;
      rd_addr_d = res_addr;
      rd_data_d = res_data;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      rd_data_q <= rd_data_d;
    end
  end

  // Storage needs no reset: entries are only read when covered by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wr_ptr_q] <= res_addr;
      data_q[wr_ptr_q] <= res_data;
    end
  end

  // Walk oldest to youngest so later matches override; output register is the oldest pending write.
  always_comb begin
    logic [PW-1:0] idx;
    idx     = '0;
    q1_hit  = 1'b0;
    q1_data = '0;
    q2_hit  = 1'b0;
    q2_data = '0;
    if (rd_we_q && (q1_addr != '0) && (rd_addr_q == q1_addr)) begin
      q1_hit  = 1'b1;
      q1_data = rd_data_q;
    end
    if (rd_we_q && (q2_addr != '0) && (rd_addr_q == q2_addr)) begin
      q2_hit  = 1'b1;
      q2_data = rd_data_q;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if ((CW'(i) < count_q) && (q1_addr != '0) && (addr_q[idx] == q1_addr)) begin
        q1_hit  = 1'b1;
        q1_data = data_q[idx];
      end
      if ((CW'(i) < count_q) && (q2_addr != '0) && (addr_q[idx] == q2_addr)) begin
        q2_hit  = 1'b1;
        q2_data = data_q[idx];
      end
    end
  end

  assign rd_we   = rd_we_q;
  assign rd_addr = rd_addr_q;
  assign rd_data = rd_data_q;
  assign busy    = (count_q != '0) | rd_we_q;

endmodule

// File: tb/tb_reg_wb_ctrl.sv
// Testbench for reg_wb_ctrl: directed vector table, hand sequences, and randomized traffic against a queue model.
module tb_reg_wb_ctrl;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          res_valid;
  logic          res_ready;
  logic [AW-1:0] res_addr;
  logic [DW-1:0] res_data;
  logic          rd_we;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic [AW-1:0] q1_addr;
  logic          q1_hit;
  logic [DW-1:0] q1_data;
  logic [AW-1:0] q2_addr;
  logic          q2_hit;
  logic [DW-1:0] q2_data;
  logic          busy;

  always #5 clk = ~clk;

  reg_wb_ctrl #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .res_valid(res_valid), .res_ready(res_ready), .res_addr(res_addr), .res_data(res_data),
    .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .q1_addr(q1_addr), .q1_hit(q1_hit), .q1_data(q1_data),
    .q2_addr(q2_addr), .q2_hit(q2_hit), .q2_data(q2_data),
    .busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Reference: pending writes as an ordered list plus the value sitting in the output register.
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;

  function automatic void fwd(input logic [AW-1:0] a, output logic h, output logic [DW-1:0] d);
    h = 1'b0;
    d = '0;
    if (a == '0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (mq[i].a == a) begin
        h = 1'b1;
        d = mq[i].d;
        return;
      end
    end
    if (m_we && m_addr == a) begin
      h = 1'b1;
      d = m_data;
    end
  endfunction

  task automatic model_check();
    logic          h;
    logic [DW-1:0] d;
    chk("res_ready", res_ready, (!rst && mq.size() < DEPTH));
    chk("rd_we", rd_we, m_we);
    chk("rd_addr", rd_addr, m_addr);
    chk("rd_data", rd_data, m_data);
    chk("busy", busy, (mq.size() != 0) || m_we);
    fwd(q1_addr, h, d);
    chk("q1_hit", q1_hit, h);
    chk("q1_data", q1_data, d);
    fwd(q2_addr, h, d);
    chk("q2_hit", q2_hit, h);
    chk("q2_data", q2_data, d);
  endtask

  task automatic advance();
    bit   acc;
    bit   was_empty;
    ent_t e;
    @(posedge clk);
    acc       = !rst && res_valid && (mq.size() < DEPTH);
    was_empty = (mq.size() == 0);
    if (rst) begin
      mq.delete();
      m_we   = 1'b0;
      m_addr = '0;
      m_data = '0;
    end else begin
      if (!was_empty) begin
        e      = mq.pop_front();
        m_we   = 1'b1;
        m_addr = e.a;
        m_data = e.d;
      end else begin
        m_we = 1'b0;
      end
      if (acc && res_addr != '0) begin
`ifdef WB_BYPASS_EN
        if (was_empty) begin
          m_we   = 1'b1;
          m_addr = res_addr;
          m_data = res_data;
        end else begin
          mq.push_back('{res_addr, res_data});
        end
`else
        mq.push_back('{res_addr, res_data});
`endif
      end
    end
    #1;
  endtask

  task automatic tick();
    @(negedge clk);
    model_check();
    advance();
  endtask

  // Write log of what the bank actually receives.
  bit            log_en = 1'b0;
  logic [AW-1:0] wlog[$];
  always @(negedge clk) begin
    if (log_en && rd_we === 1'b1) wlog.push_back(rd_addr);
  end

  typedef struct {
    logic          rst, v;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [AW-1:0] q1, q2;
    logic          e_rdy, e_we;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_d;
    logic          e_busy, e_h1;
    logic [DW-1:0] e_d1;
    logic          e_h2;
    logic [DW-1:0] e_d2;
  } vec_t;

  vec_t tbl[10];

  initial begin
    tbl[0] = '{1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd0, 1'b1, 1'b0, 5'd0, 32'h0,        1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[1] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b1, 1'b0, 5'd0, 32'h0,        1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd5, 1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'hDEADBEEF, 1'b1, 32'hDEADBEEF};
    tbl[3] = '{1'b0, 1'b1, 5'd0, 32'h12345678, 5'd0, 5'd5, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 5'd7, 32'h33,       5'd7, 5'd0, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0};
    tbl[5] = '{1'b0, 1'b1, 5'd7, 32'h11,       5'd7, 5'd7, 1'b1, 1'b0, 5'd5, 32'hDEADBEEF, 1'b1, 1'b1, 32'h33,       1'b1, 32'h33};
    tbl[6] = '{1'b0, 1'b1, 5'd7, 32'h22,       5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 32'h33,       1'b1, 1'b1, 32'h11,       1'b1, 32'h11};
    tbl[7] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd9, 1'b1, 1'b1, 5'd7, 32'h11,       1'b1, 1'b1, 32'h22,       1'b0, 32'h0};
    tbl[8] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 1'b1, 5'd7, 32'h22,       1'b1, 1'b1, 32'h22,       1'b1, 32'h22};
    tbl[9] = '{1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd7, 1'b1, 1'b0, 5'd7, 32'h22,       1'b0, 1'b0, 32'h0,        1'b0, 32'h0};

    rst = 1'b1; res_valid = 1'b0; res_addr = '0; res_data = '0; q1_addr = '0; q2_addr = '0;
    m_we = 1'b0; m_addr = '0; m_data = '0;
    advance();
    advance();
    @(negedge clk);
    model_check();
    chk("reset_rd_we", rd_we, 1'b0);
    chk("reset_ready_low", res_ready, 1'b0);
    advance();

    // Directed vector table
    foreach (tbl[k]) begin
      rst = tbl[k].rst; res_valid = tbl[k].v; res_addr = tbl[k].a; res_data = tbl[k].d;
      q1_addr = tbl[k].q1; q2_addr = tbl[k].q2;
      @(negedge clk);
`ifndef WB_BYPASS_EN
      chk($sformatf("tbl%0d_ready", k), res_ready, tbl[k].e_rdy);
      chk($sformatf("tbl%0d_we", k), rd_we, tbl[k].e_we);
      chk($sformatf("tbl%0d_addr", k), rd_addr, tbl[k].e_a);
      chk($sformatf("tbl%0d_data", k), rd_data, tbl[k].e_d);
      chk($sformatf("tbl%0d_busy", k), busy, tbl[k].e_busy);
      chk($sformatf("tbl%0d_q1hit", k), q1_hit, tbl[k].e_h1);
      chk($sformatf("tbl%0d_q1data", k), q1_data, tbl[k].e_d1);
      chk($sformatf("tbl%0d_q2hit", k), q2_hit, tbl[k].e_h2);
      chk($sformatf("tbl%0d_q2data", k), q2_data, tbl[k].e_d2);
`endif
      model_check();
      advance();
    end
    res_valid = 1'b0;

    // Back-to-back fill with valid held high: all six written in order
    wlog.delete();
    log_en = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      bit hs;
      hs = 1'b0;
      res_valid = 1'b1; res_addr = AW'(k); res_data = 32'h100 * k; q1_addr = AW'(k); q2_addr = AW'(k - 1);
      for (int w = 0; w < 10 && !hs; w++) begin
        @(negedge clk);
        model_check();
        hs = res_ready;
        advance();
      end
      if (!hs) chk("fill_handshake_timeout", 32'd0, 32'd1);
    end
    res_valid = 1'b0;
    for (int w = 0; w < 6; w++) tick();
    log_en = 1'b0;
    chk("fill_write_count", wlog.size(), 6);
    for (int k = 0; k < 6 && k < wlog.size(); k++) chk($sformatf("fill_order%0d", k), wlog[k], k + 1);

    // Reset mid-operation: nothing pushed before the reset may reach the bank
    for (int k = 0; k < 3; k++) begin
      res_valid = 1'b1; res_addr = AW'(10 + k); res_data = 32'hA0 + k;
      tick();
    end
    rst = 1'b1; res_addr = 5'd13;
    tick();
    rst = 1'b0; res_valid = 1'b0;
    wlog.delete();
    log_en = 1'b1;
    @(negedge clk);
    chk("post_rst_we", rd_we, 1'b0);
    chk("post_rst_addr", rd_addr, 0);
    chk("post_rst_data", rd_data, 0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_ready", res_ready, 1'b1);
    model_check();
    advance();
    for (int w = 0; w < 4; w++) tick();
    log_en = 1'b0;
    chk("post_rst_no_writes", wlog.size(), 0);

    // Randomized traffic against the model
    for (int n = 0; n < 400; n++) begin
      rst       = ($urandom_range(0, 49) == 0);
      res_valid = $urandom_range(0, 2) != 0;
      res_addr  = AW'($urandom_range(0, 7));
      res_data  = $urandom;
      q1_addr   = AW'($urandom_range(0, 7));
      q2_addr   = AW'($urandom_range(0, 7));
      tick();
    end
    rst = 1'b0; res_valid = 1'b0;
    for (int w = 0; w < 4; w++) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
